// File: rtl/csr_status_log.sv
// rtl/csr_status_log.sv - core status/exception CSR with start-time enable mask and exception FIFO log
module csr_status_log #(
    parameter int EXC_NUM   = 8,
    parameter int PC_W      = 32,
    parameter int LOG_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_pulse,
    input  logic [EXC_NUM-1:0]             start_cfg,
    input  logic                           wfi_vld,
    input  logic                           exc_vld,
    input  logic [EXC_NUM-1:0]             exc_vec,
    input  logic [PC_W-1:0]                exc_pc,
    input  logic                           wake_pulse,
    input  logic                           log_pop,
    output logic [1:0]                     core_status,
    output logic [EXC_NUM-1:0]             core_cfg,
    output logic [EXC_NUM-1:0]             exc_sticky,
    output logic [PC_W-1:0]                fatal_pc,
    output logic                           log_vld,
    output logic [EXC_NUM-1:0]             log_exc,
    output logic [PC_W-1:0]                log_pc,
    output logic [$clog2(LOG_DEPTH+1)-1:0] log_count,
    output logic                           log_ovf,
    output logic [CNT_W-1:0]               exc_cnt
);
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int LCW   = $clog2(LOG_DEPTH+1);
    localparam int ENT_W = EXC_NUM + PC_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WFI  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [EXC_NUM-1:0]   cfg_q, cfg_d;
    logic [EXC_NUM-1:0]   sticky_q, sticky_d;
    logic [PC_W-1:0]      fatal_pc_q, fatal_pc_d;
    logic [ENT_W-1:0]     mem_q [LOG_DEPTH];
    logic [ENT_W-1:0]     mem_d [LOG_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LCW-1:0]       count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic acc, fatal, pop_ok, full;

    // start_pulse masks every other event in its cycle
    assign acc    = exc_vld && (state_q == ST_RUN) && !start_pulse;
    assign fatal  = acc && (|(exc_vec & cfg_q));
    assign pop_ok = log_pop && (count_q != '0) && !start_pulse;
    assign full   = (count_q == LCW'(LOG_DEPTH));

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        sticky_d   = sticky_q;
        fatal_pc_d = fatal_pc_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;

        if (start_pulse) begin
            state_d    = ST_RUN;
            cfg_d      = start_cfg;
            sticky_d   = '0;
            fatal_pc_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (fatal) begin
                        state_d    = ST_HALT;
                        fatal_pc_d = exc_pc;
                    end else if (wfi_vld) begin
                        state_d = ST_WFI;
                    end
                end
                ST_WFI:  if (wake_pulse) state_d = ST_RUN;
                default: state_d = state_q;
            endcase

            if (acc) begin
                sticky_d = sticky_q | exc_vec;
                cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            end

            if (pop_ok)
                rd_ptr_d = rd_ptr_q + 1'b1;

            // A pop in the same cycle frees the slot, so a full log still accepts the push
            if (acc && (pop_ok || !full)) begin
                mem_d[wr_ptr_q] = {exc_vec, exc_pc};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end else if (acc) begin
                ovf_d = 1'b1;
            end

            if (acc && !pop_ok && !full)
                count_d = count_q + 1'b1;
            else if (pop_ok && !acc)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            sticky_q   <= '0;
            fatal_pc_q <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            sticky_q   <= sticky_d;
            fatal_pc_q <= fatal_pc_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign core_status = state_q;
    assign core_cfg    = cfg_q;
    assign exc_sticky  = sticky_q;
    assign fatal_pc    = fatal_pc_q;
    assign log_vld     = (count_q != '0);
    assign log_exc     = mem_q[rd_ptr_q][ENT_W-1:PC_W];
    assign log_pc      = mem_q[rd_ptr_q][PC_W-1:0];
    assign log_count   = count_q;
    assign log_ovf     = ovf_q;
    assign exc_cnt     = cnt_q;
endmodule
